// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read side of an asynchronous 16-entry FIFO. It synchronizes the writer's
// Gray pointer and keeps the read pointer. It also drives the memory read
// address and holds one registered output word with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-low reset (0 = reset asserted)
//   wptr_gray  [4:0] writer pointer, Gray-coded (bit 4 = wrap bit)
//   read_data  [7:0] combinational memory output for raddr
//   raddr      [3:0] memory read address (= rptr_bin[3:0])
//   rptr_gray  [4:0] registered Gray read pointer, returned to the writer
//   empty      no unread word in memory (the output register is not counted)
//   rd_data    [7:0] registered output word
//   rd_valid   rd_data holds a valid word
//   rd_ready   consumer accepts rd_data
//   rd_level   [4:0] registered memory fill level (only with FIFO_RD_LEVEL_EN)
//
// Configuration macro: FIFO_RD_LEVEL_EN adds the rd_level output.
//
// Handshake: a word moves to the consumer on every clk edge where
// rd_valid && rd_ready. While rd_valid is high and rd_ready is low, rd_data
// and rd_valid are frozen. rd_valid never drops unless the word was taken.
// ---------------------------------------------------------------------------
module fifo_read_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] wptr_gray,
    input  logic [7:0] read_data,
    output logic [3:0] raddr,
    output logic [4:0] rptr_gray,
    output logic       empty,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [4:0] rd_level
`endif
);

    logic [4:0] wq1;
    logic [4:0] wq2;
    logic [4:0] rptr_bin;
    logic [4:0] rptr_bin_next;
    logic       load;

    // empty compares registered values only, so it is glitch-free. The reader
    // can never step past the synchronized write pointer.
    always_comb begin
        empty         = (rptr_gray == wq2);
        load          = !empty && (!rd_valid || rd_ready);
        rptr_bin_next = rptr_bin + 5'd1;
    end

    assign raddr = rptr_bin[3:0];

    // Two-flop synchronizer for the writer's Gray pointer. Only one bit of a
    // Gray pointer changes per increment, so any sampled value is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wq1 <= 5'd0;
            wq2 <= 5'd0;
        end else begin
            wq1 <= wptr_gray;
            wq2 <= wq1;
        end
    end

    // Binary and Gray pointers advance together, so rptr_gray stays registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_bin  <= 5'd0;
            rptr_gray <= 5'd0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
        end else if (load) begin
            rd_data   <= read_data;
            rd_valid  <= 1'b1;
            rptr_bin  <= rptr_bin_next;
            rptr_gray <= rptr_bin_next ^ (rptr_bin_next >> 1);
        end else if (rd_valid && rd_ready) begin
            // Word taken and nothing behind it: rd_data keeps its last value.
            rd_valid  <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Modulo-32 difference of two 5-bit pointers. It spans 0..16 because the
    // writer never gets more than 16 entries ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_level <= 5'd0;
        end else begin
            rd_level <= gray2bin(wq2) - rptr_bin;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  logic       reset;
  logic [4:0] wptr_gray;
  logic [7:0] read_data;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       empty;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0] rd_level;
`endif

  logic [7:0] mem [16];
  assign read_data = mem[raddr];

  fifo_read_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .wptr_gray (wptr_gray),
    .read_data (read_data),
    .raddr     (raddr),
    .rptr_gray (rptr_gray),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] from_gray(input logic [4:0] g);
    logic [4:0] b;
    b = 5'd0;
    for (int i = 4; i >= 0; i--) begin
      for (int j = i; j <= 4; j++) b[i] = b[i] ^ g[j];
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset is released well before the next edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0] wptr;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    logic [4:0] eg;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wptr_gray = vecs[i].wptr;
      rd_ready  = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].ev);
      chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].ed);
      chk($sformatf("vec%0d empty", i), empty, vecs[i].ee);
      chk($sformatf("vec%0d rptr_gray", i), rptr_gray, vecs[i].eg);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [4:0] wbin;
    int n_wr, n_rd;
    logic seen31, seen_wrap;

    // single word: mem[0] = A5, write pointer 0 -> 1
    vecs[0]  = '{5'd1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0};
    vecs[1]  = '{5'd1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};
    vecs[2]  = '{5'd1, 1'b1, 1'b1, 8'hA5, 1'b1, 5'd1};
    vecs[3]  = '{5'd1, 1'b1, 1'b0, 8'hA5, 1'b1, 5'd1};
    // backpressure: 4 words, write pointer gray 6, ready low for 5 cycles
    vecs[4]  = '{5'd6, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
    vecs[5]  = '{5'd6, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0};
    vecs[6]  = '{5'd6, 1'b0, 1'b1, 8'h11, 1'b0, 5'd1};
    vecs[7]  = '{5'd6, 1'b0, 1'b1, 8'h11, 1'b0, 5'd1};
    vecs[8]  = '{5'd6, 1'b0, 1'b1, 8'h11, 1'b0, 5'd1};
    vecs[9]  = '{5'd6, 1'b1, 1'b1, 8'h22, 1'b0, 5'd3};
    vecs[10] = '{5'd6, 1'b1, 1'b1, 8'h33, 1'b0, 5'd2};
    vecs[11] = '{5'd6, 1'b1, 1'b1, 8'h44, 1'b1, 5'd6};
    vecs[12] = '{5'd6, 1'b1, 1'b0, 8'h44, 1'b1, 5'd6};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]    = 8'hA5;
    wptr_gray = 5'd0;
    rd_ready  = 1'b0;

    // reset with the clock stopped
    reset = 1'b0;
    #1;
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset empty", empty, 1'b1);
    chk("reset raddr", raddr, 4'd0);
    chk("reset rptr_gray", rptr_gray, 5'd0);
    chk("reset rd_data", rd_data, 8'h00);
`ifdef FIFO_RD_LEVEL_EN
    chk("reset rd_level", rd_level, 5'd0);
`endif

    clk_en = 1'b1;
    #2;
    reset = 1'b1;
    run_vecs(0, 3);

    // backpressure
    step();
    reset = 1'b0;
    wptr_gray = 5'd0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    #2;
    reset = 1'b1;
    run_vecs(4, 12);

    // wrap-around streaming of 40 words
    step();
    wptr_gray = 5'd0;
    rd_ready  = 1'b1;
    do_reset();
    wbin = 5'd0; n_wr = 0; n_rd = 0; seen31 = 1'b0; seen_wrap = 1'b0;
    for (int cyc = 0; cyc < 400 && n_rd < 40; cyc++) begin
      if (n_wr < 40 && 5'(wbin - from_gray(rptr_gray)) < 5'd16) begin
        mem[wbin[3:0]] = 8'(n_wr * 7 + 3);
        exp_q.push_back(8'(n_wr * 7 + 3));
        wbin = wbin + 5'd1;
        wptr_gray = to_gray(wbin);
        n_wr++;
      end
      step();
      if (rptr_gray == 5'b10000) seen31 = 1'b1;
      if (seen31 && rptr_gray == 5'b00000) seen_wrap = 1'b1;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wrap extra word: got %0h expected none", rd_data);
        end else begin
          chk($sformatf("wrap word%0d", n_rd), rd_data, exp_q.pop_front());
        end
        n_rd++;
      end
    end
    chk("wrap word count", n_rd, 40);
    chk("wrap saw rptr bin31", seen31, 1'b1);
    chk("wrap saw rptr bin0 after 31", seen_wrap, 1'b1);
    step();
    chk("wrap final raddr", raddr, 4'd8);
    chk("wrap final rptr_gray", rptr_gray, 5'd12);
    chk("wrap final empty", empty, 1'b1);
    chk("wrap final rd_valid", rd_valid, 1'b0);

    // mid-transfer reset with 3 words still pending
    wptr_gray = 5'd0;
    rd_ready  = 1'b0;
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    wptr_gray = 5'd6;
    step(); step(); step();
    chk("midrst pre rd_valid", rd_valid, 1'b1);
    chk("midrst pre rd_data", rd_data, 8'h11);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst rd_valid", rd_valid, 1'b0);
    chk("midrst empty", empty, 1'b1);
    chk("midrst raddr", raddr, 4'd0);
    chk("midrst rptr_gray", rptr_gray, 5'd0);
    chk("midrst rd_data", rd_data, 8'h00);
    wptr_gray = 5'd0;
    step();
    reset = 1'b1;

    // no load while the write pointer stays at 0
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("idle%0d rd_valid", i), rd_valid, 1'b0);
      chk($sformatf("idle%0d empty", i), empty, 1'b1);
    end

    // first load lands on the third edge after the pointer moves
    wptr_gray = 5'd1;
    step();
    chk("lat edge1 rd_valid", rd_valid, 1'b0);
    step();
    chk("lat edge2 rd_valid", rd_valid, 1'b0);
    step();
    chk("lat edge3 rd_valid", rd_valid, 1'b1);
    chk("lat edge3 rd_data", rd_data, 8'h11);

`ifdef FIFO_RD_LEVEL_EN
    // level with 16 words written and the consumer stalled
    wptr_gray = 5'd0;
    rd_ready  = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h40);
    wptr_gray = to_gray(5'd16);
    for (int i = 0; i < 6; i++) step();
    chk("level rd_valid", rd_valid, 1'b1);
    chk("level rd_data", rd_data, 8'h40);
    chk("level rd_level", rd_level, 5'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
- REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
- REQ-002 SHALL: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- REQ-003 SHALL: wptr_gray  input  5  write pointer from the FIFO writer, Gray-coded. Bits [3:0] address the 16-entry memory; bit 4 is the wrap bit.
- REQ-004 SHALL: read_data  input  8  combinational memory output for raddr.
- REQ-005 SHALL: raddr  output  4  memory read address, equal to rptr_bin[3:0].
- REQ-006 SHALL: rptr_gray  output  5  registered Gray read pointer returned to the writer for full detection.
- REQ-007 SHALL: empty  output  1  high when the memory holds no unread word; the output register is excluded.
- REQ-008 SHALL: rd_data  output  8  registered output word.
- REQ-009 SHALL: rd_valid  output  1  rd_data holds a valid word.
- REQ-010 SHALL: rd_ready  input  1  consumer accepts rd_data on a clk edge where rd_valid && rd_ready.

Function
- REQ-011 SHALL: wptr_gray passes through a 2-flop synchronizer (wq1, wq2) before any use.
- REQ-012 SHALL: internal read pointer rptr_bin is 5 bits binary; rptr_gray = rptr_bin ^ (rptr_bin >> 1), registered together with rptr_bin.
- REQ-013 SHALL: empty = (rptr_gray == wq2), combinational from registers only.
- REQ-014 SHALL: load = !empty && (!rd_valid || rd_ready).
- REQ-015 SHALL: on a load edge:
  - rd_data <= read_data at the current raddr;
  - rd_valid <= 1;
  - rptr_bin increments by 1, modulo 32.
- REQ-016 SHALL: on an edge with rd_valid && rd_ready && empty: rd_valid <= 0, rd_data holds, pointer holds.
- REQ-017 SHALL: with rd_valid && !rd_ready, rd_data, rd_valid and the pointers hold (no overwrite, no drop).
- REQ-018 SHALL: sustained throughput is one word per cycle while not empty and rd_ready = 1.
- REQ-019 SHALL: latency from a wptr_gray change to rd_valid = 3 edges (2 sync + 1 load) when the output register is free.
- REQ-020 SHALL: pointer wrap 31 -> 0 toggles the wrap bit; raddr wraps 15 -> 0 with no gap or repeat.
- REQ-021 SHALL: words are delivered in exactly the order written; none duplicated or skipped.
- REQ-022 SHALL: the block never issues reads past wq2. Underflow is structurally impossible.

Reset
- REQ-023 SHALL: while reset = 0, asynchronously force:
  - wq1, wq2, rptr_bin, rptr_gray = 0;
  - raddr = 0, rd_data = 8'h00, rd_valid = 0, empty = 1.
- REQ-024 SHALL: reset asserted mid-transfer discards the output word and all pointer state immediately, without waiting for clk.
- REQ-025 SHALL: after reset deasserts, the first load occurs no earlier than the third clk edge, and only if wptr_gray != 0.

Configuration
- REQ-026 SHALL: macro FIFO_RD_LEVEL_EN, when defined, adds output rd_level (5 bits, registered):
  - value = (gray2bin(wq2) - rptr_bin) mod 32, range 0..16;
  - reset value 0;
  - updated every cycle.
- REQ-027 SHALL: without FIFO_RD_LEVEL_EN, the rd_level port and its logic are absent; all other behaviour is identical.

Verification
- REQ-028 SHALL: reset check. Assert reset = 0 with clk stopped -> rd_valid = 0, empty = 1, raddr = 0, rptr_gray = 0, rd_data = 00.
- REQ-029 SHALL: single word. Memory[0] = 8'hA5, wptr_gray 0 -> 1 -> rd_valid rises on the 3rd edge; rd_data = A5; rptr_gray = 1; empty = 1 thereafter.
- REQ-030 SHALL: backpressure.
  - Stimulus: 4 words 11, 22, 33, 44 (wptr_gray = 6); rd_ready = 0 for 5 cycles, then 1.
  - Response: rd_data holds 11 while stalled, then 22, 33, 44 on consecutive edges; rd_valid drops after 44.
- REQ-031 SHALL: wrap-around. Stream 40 words with rd_ready = 1 and the writer never exceeding 16 ahead -> output sequence matches input; rptr_gray passes 10000 (bin 31) then 00000 (bin 0).
- REQ-032 SHALL: mid-transfer reset. Reset pulse while rd_valid = 1 and 3 words pending -> outputs return to REQ-023 values within the same cycle.
- REQ-033 SHALL: level check (FIFO_RD_LEVEL_EN defined). 16 words written, rd_ready = 0 -> rd_level = 15 once the output register is loaded and wq2 is settled.
